// File: rtl/video_scan_out.sv
// video_scan_out: parametrised VGA scan-out of RGB332/RGB565/XRGB8888 words from a show-ahead FIFO.
// Define VIDEO_TEST_PATTERN_EN to let test_pattern replace the FIFO stream with colour bars.
module video_scan_out #(
    parameter int M1 = 1280,
    parameter int M2 = 1328,
    parameter int M3 = 1440,
    parameter int M4 = 1688,
    parameter int M5 = 1024,
    parameter int M6 = 1025,
    parameter int M7 = 1028,
    parameter int M8 = 1066,
    parameter bit HS_NEG = 1'b0,
    parameter bit VS_NEG = 1'b0,
    parameter int BAR_SHIFT = 7
) (
    input  logic        video_clock,
    input  logic        video_reset_n,
    input  logic [1:0]  mode,
    input  logic [31:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    input  logic        clr_underflow,
    input  logic        test_pattern,
    output logic [9:0]  oVGA_R,
    output logic [9:0]  oVGA_G,
    output logic [9:0]  oVGA_B,
    output logic        oVGA_BLANK_N,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_CLOCK,
    output logic        frame_start,
    output logic [15:0] underflow_count
);
    localparam int XW = $clog2(M4);
    localparam int YW = $clog2(M8);
    localparam logic [XW-1:0] H_VIS = XW'(M1);
    localparam logic [XW-1:0] H_SS = XW'(M2);
    localparam logic [XW-1:0] H_SE = XW'(M3);
    localparam logic [XW-1:0] X_LAST = XW'(M4 - 1);
    localparam logic [YW-1:0] V_VIS = YW'(M5);
    localparam logic [YW-1:0] V_SS = YW'(M6);
    localparam logic [YW-1:0] V_SE = YW'(M7);
    localparam logic [YW-1:0] Y_LAST = YW'(M8 - 1);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0] mode_q;
    logic [31:0] word_q, pix_word, sel;
    logic under_q, visible, lane0, tp_act, pop, underflow, red;
    logic [2:0] bar;
    logic [9:0] fr, fg, fb, nr, ng, nb;
`ifdef VIDEO_TEST_PATTERN_EN
    assign tp_act = test_pattern;
    assign bar = x[BAR_SHIFT+2:BAR_SHIFT];
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
    assign tp_act = 1'b0;
    assign bar = 3'b000;
`endif
    assign visible = (x < H_VIS) && (y < V_VIS);
    assign lane0 = mode_q == 2'd2 || (mode_q == 2'd1 ? !x[0] : x[1:0] == 2'd0);
    assign pop = visible && lane0 && !fifo_empty && !tp_act;
    assign underflow = visible && lane0 && fifo_empty && !tp_act;
    assign fifo_rdreq = pop && video_reset_n;
    // lane 0 shows the head word directly; later lanes replay the word stored at the pop
    assign pix_word = lane0 ? fifo_q : word_q;
    assign sel = mode_q == 2'd0 ? pix_word << {x[1:0], 3'b000} : mode_q == 2'd1 ? pix_word << {x[0], 4'b0000} : pix_word;
    assign red = lane0 ? underflow : under_q;
    always_comb begin
        fr = {sel[31:29], sel[31:29], sel[31:29], sel[31]};
        fg = {sel[28:26], sel[28:26], sel[28:26], sel[28]};
        fb = {5{sel[25:24]}};
        if (mode_q == 2'd1) begin
            fr = {2{sel[31:27]}};
            fg = {sel[26:21], sel[26:23]};
            fb = {2{sel[20:16]}};
        end else if (mode_q == 2'd2) begin
            fr = {sel[23:16], sel[23:22]};
            fg = {sel[15:8], sel[15:14]};
            fb = {sel[7:0], sel[7:6]};
        end
    end
    assign nr = !visible ? 10'd0 : tp_act ? {10{bar[2]}} : red ? 10'h3FF : fr;
    assign ng = !visible ? 10'd0 : tp_act ? {10{bar[1]}} : red ? 10'd0 : fg;
    assign nb = !visible ? 10'd0 : tp_act ? {10{bar[0]}} : red ? 10'd0 : fb;
    assign oVGA_SYNC_N = 1'b1;
    assign oVGA_CLOCK = video_clock;
    always_ff @(posedge video_clock or negedge video_reset_n) begin
        if (!video_reset_n) begin
            x <= '0;
            y <= '0;
            mode_q <= 2'd0;
            word_q <= '0;
            under_q <= 1'b0;
            oVGA_R <= '0;
            oVGA_G <= '0;
            oVGA_B <= '0;
            oVGA_BLANK_N <= 1'b0;
            oVGA_HS <= HS_NEG;
            oVGA_VS <= VS_NEG;
            frame_start <= 1'b0;
            underflow_count <= '0;
        end else begin
            x <= x == X_LAST ? '0 : x + 1'b1;
            if (x == X_LAST) y <= y == Y_LAST ? '0 : y + 1'b1;
            if (x == X_LAST && y == Y_LAST) mode_q <= mode == 2'd3 ? 2'd0 : mode;
            if (pop) word_q <= fifo_q;
            if (visible && lane0 && !tp_act) under_q <= fifo_empty;
            oVGA_R <= nr;
            oVGA_G <= ng;
            oVGA_B <= nb;
            oVGA_BLANK_N <= visible;
            oVGA_HS <= HS_NEG ^ (x >= H_SS && x < H_SE);
            oVGA_VS <= VS_NEG ^ (y >= V_SS && y < V_SE);
            frame_start <= x == '0 && y == V_SS;
            underflow_count <= clr_underflow ? '0 : underflow && underflow_count != 16'hFFFF ? underflow_count + 16'd1 : underflow_count;
        end
    end
endmodule

// File: tb/tb_video_scan_out.sv
// tb_video_scan_out: directed scoreboard bench for video_scan_out on the 8/10/12/14 x 4/5/6/8 modeline.
// A second instance on a nearly all-visible modeline starves continuously to reach counter saturation.
module tb_video_scan_out;
    typedef struct packed {
        logic [9:0] r, g, b;
        logic bl, hs, vs, fs;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, sat_rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [31:0] wl [2];
    bit widx = 1'b0;
    logic [31:0] fifo_q;
    logic starve = 1'b0, clr = 1'b0, tp = 1'b0;
    logic fifo_empty, fifo_rdreq, sync_n, vclk, frame_start, bl_n, hs, vs;
    logic [9:0] r, g, b;
    logic [15:0] ucnt;
    logic [9:0] sr, sg, sb_;
    logic s_rd, s_bl, s_hs, s_vs, s_sync, s_clk, s_fs;
    logic [15:0] s_cnt;

    int checks = 0, errors = 0, pops = 0, fs_seen = 0, bl_seen = 0, hs_seen = 0, cyc = 0;
    int mx = 0, my = 0, mmode = 0, mcnt = 0;
    logic [31:0] gw = '0;
    bit gred = 1'b0;
    exp_t sbq[$];

    assign fifo_q = wl[widx];
    assign fifo_empty = starve;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    video_scan_out #(.M1(8), .M2(10), .M3(12), .M4(14), .M5(4), .M6(5), .M7(6), .M8(8),
                     .HS_NEG(1'b0), .VS_NEG(1'b0), .BAR_SHIFT(0)) dut (
        .video_clock(clk), .video_reset_n(rst_n), .mode(mode), .fifo_q(fifo_q),
        .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq), .clr_underflow(clr),
        .test_pattern(tp), .oVGA_R(r), .oVGA_G(g), .oVGA_B(b), .oVGA_BLANK_N(bl_n),
        .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_SYNC_N(sync_n), .oVGA_CLOCK(vclk),
        .frame_start(frame_start), .underflow_count(ucnt));

    video_scan_out #(.M1(64), .M2(65), .M3(66), .M4(67), .M5(64), .M6(65), .M7(66), .M8(67),
                     .HS_NEG(1'b0), .VS_NEG(1'b0), .BAR_SHIFT(0)) u_sat (
        .video_clock(clk), .video_reset_n(sat_rst_n), .mode(2'd2), .fifo_q(32'h0),
        .fifo_empty(1'b1), .fifo_rdreq(s_rd), .clr_underflow(1'b0),
        .test_pattern(1'b0), .oVGA_R(sr), .oVGA_G(sg), .oVGA_B(sb_), .oVGA_BLANK_N(s_bl),
        .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oVGA_SYNC_N(s_sync), .oVGA_CLOCK(s_clk),
        .frame_start(s_fs), .underflow_count(s_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ex(input logic [7:0] v, input int n);
        logic [9:0] res;
        for (int i = 0; i < 10; i++) res[9 - i] = v[n - 1 - (i % n)];
        return res;
    endfunction

    task automatic px(input string tag, input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb);
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_g"}, 32'(g), 32'(eg));
        chk({tag, "_b"}, 32'(b), 32'(eb));
    endtask

    task automatic rst_chk(input string tag);
        px(tag, 10'd0, 10'd0, 10'd0);
        chk({tag, "_blank"}, 32'(bl_n), 32'd0);
        chk({tag, "_hs"}, 32'(hs), 32'd0);
        chk({tag, "_vs"}, 32'(vs), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_cnt"}, 32'(ucnt), 32'd0);
        chk({tag, "_rdreq"}, 32'(fifo_rdreq), 32'd0);
        chk({tag, "_sync_n"}, 32'(sync_n), 32'd1);
    endtask

    task automatic tick();
        exp_t e;
        int ppw, ln;
        bit vis, tpa, rd;
        logic [31:0] sh;
        @(negedge clk);
        vis = mx < 8 && my < 4;
        ppw = mmode == 0 ? 4 : mmode == 1 ? 2 : 1;
        ln = mx % ppw;
`ifdef VIDEO_TEST_PATTERN_EN
        tpa = tp;
`else
        tpa = 1'b0;
`endif
        chk("rdreq", 32'(fifo_rdreq), 32'(vis && ln == 0 && !fifo_empty && !tpa));
        rd = fifo_rdreq;
        if (rd) pops++;
        if (vis && ln == 0 && !tpa) begin
            gred = fifo_empty;
            if (!fifo_empty) gw = fifo_q;
        end
        e = '0;
        e.bl = vis;
        e.hs = mx >= 10 && mx < 12;
        e.vs = my == 5;
        e.fs = mx == 0 && my == 5;
        if (vis) begin
            if (tpa) begin
                e.r = mx[2] ? 10'h3FF : 10'h0;
                e.g = mx[1] ? 10'h3FF : 10'h0;
                e.b = mx[0] ? 10'h3FF : 10'h0;
            end else if (gred) begin
                e.r = 10'h3FF;
            end else if (mmode == 0) begin
                sh = gw >> (24 - 8 * ln);
                e.r = ex(8'(sh[7:5]), 3);
                e.g = ex(8'(sh[4:2]), 3);
                e.b = ex(8'(sh[1:0]), 2);
            end else if (mmode == 1) begin
                sh = gw >> (16 - 16 * ln);
                e.r = ex(8'(sh[15:11]), 5);
                e.g = ex(8'(sh[10:5]), 6);
                e.b = ex(8'(sh[4:0]), 5);
            end else begin
                e.r = ex(gw[23:16], 8);
                e.g = ex(gw[15:8], 8);
                e.b = ex(gw[7:0], 8);
            end
        end
        if (clr) mcnt = 0;
        else if (vis && ln == 0 && fifo_empty && !tpa && mcnt < 65535) mcnt++;
        e.cnt = 16'(mcnt);
        if (mx == 13 && my == 7) mmode = mode == 2'd3 ? 0 : int'(mode);
        mx++;
        if (mx == 14) begin
            mx = 0;
            my = (my + 1) % 8;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (rd) widx = ~widx;
        e = sbq.pop_front();
        px("pix", e.r, e.g, e.b);
        chk("blank_n", 32'(bl_n), 32'(e.bl));
        chk("hs", 32'(hs), 32'(e.hs));
        chk("vs", 32'(vs), 32'(e.vs));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("underflow_count", 32'(ucnt), 32'(e.cnt));
        if (frame_start) fs_seen++;
        if (bl_n) bl_seen++;
        if (hs) hs_seen++;
    endtask

    task automatic run_to(input int tx, input int ty);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(mx == tx && my == ty) && n < 300);
        chk("run_to_reached", 32'(mx == tx && my == ty), 32'd1);
    endtask

    initial begin
        wl[0] = 32'hE01C03FF;
        wl[1] = 32'h03FFE01C;
        repeat (3) @(posedge clk);
        #1;
        rst_chk("reset");
        chk("clock_hi", 32'(vclk), 32'(clk));
        #5;
        chk("clock_lo", 32'(vclk), 32'(clk));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sat_rst_n = 1'b1;
        // RGB332 and free-running timing over two frames
        tick(); px("rgb332_p0", 10'h3FF, 10'h0, 10'h0);
        tick(); px("rgb332_p1", 10'h0, 10'h3FF, 10'h0);
        tick(); px("rgb332_p2", 10'h0, 10'h0, 10'h3FF);
        tick(); px("rgb332_p3", 10'h3FF, 10'h3FF, 10'h3FF);
        run_to(0, 0);
        run_to(0, 0);
        chk("frame_start_per_2_frames", 32'(fs_seen), 32'd2);
        chk("blank_n_high_2_frames", 32'(bl_seen), 32'd64);
        chk("hs_active_2_frames", 32'(hs_seen), 32'd32);
        pops = 0;
        repeat (14) tick();
        chk("rgb332_pops_per_line", 32'(pops), 32'd2);
        // mode change mid-frame is deferred to the next frame
        run_to(6, 1);
        mode = 2'd1;
        wl[0] = 32'hF80007E0;
        wl[1] = 32'h07E0F800;
        pops = 0;
        repeat (14) tick();
        chk("deferred_mode_pops", 32'(pops), 32'd2);
        run_to(0, 0);
        widx = 1'b0;
        pops = 0;
        tick(); px("rgb565_p0", 10'h3FF, 10'h0, 10'h0);
        tick(); px("rgb565_p1", 10'h0, 10'h3FF, 10'h0);
        repeat (12) tick();
        chk("rgb565_pops_per_line", 32'(pops), 32'd4);
        mode = 2'd2;
        wl[0] = 32'h00808080;
        wl[1] = 32'h00FFFFFF;
        run_to(0, 0);
        widx = 1'b0;
        pops = 0;
        tick(); px("xrgb_p0", 10'h202, 10'h202, 10'h202);
        tick(); px("xrgb_p1", 10'h3FF, 10'h3FF, 10'h3FF);
        repeat (12) tick();
        chk("xrgb_pops_per_line", 32'(pops), 32'd8);
        // underflow group and clear-over-increment
        mode = 2'd0;
        wl[0] = 32'hE01C03FF;
        wl[1] = 32'h03FFE01C;
        run_to(0, 0);
        widx = 1'b0;
        starve = 1'b1;
        tick();
        starve = 1'b0;
        px("underflow_p0", 10'h3FF, 10'h0, 10'h0);
        chk("underflow_count_one", 32'(ucnt), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            px("underflow_grp", 10'h3FF, 10'h0, 10'h0);
        end
        starve = 1'b1;
        clr = 1'b1;
        tick();
        starve = 1'b0;
        clr = 1'b0;
        chk("clear_wins", 32'(ucnt), 32'd0);
        // test pattern request mid-group
        run_to(0, 1);
        widx = 1'b0;
        repeat (5) tick();
        tp = 1'b1;
        tick();
`ifdef VIDEO_TEST_PATTERN_EN
        px("bar_x5", 10'h3FF, 10'h0, 10'h3FF);
`else
        px("tp_ignored_x5", 10'h3FF, 10'h3FF, 10'h3FF);
`endif
        run_to(0, 2);
        pops = 0;
        run_to(0, 3);
`ifdef VIDEO_TEST_PATTERN_EN
        chk("tp_no_pops", 32'(pops), 32'd0);
`else
        chk("tp_ignored_pops", 32'(pops), 32'd2);
`endif
        tp = 1'b0;
        // reset mid-line
        mode = 2'd2;
        run_to(0, 0);
        run_to(3, 1);
        starve = 1'b1;
        tick();
        starve = 1'b0;
        chk("pre_reset_count", 32'(ucnt), 32'd1);
        chk("pre_reset_blank", 32'(bl_n), 32'd1);
        rst_n = 1'b0;
        #1;
        rst_chk("midline_reset");
        @(posedge clk);
        #1;
        chk("rdreq_in_reset", 32'(fifo_rdreq), 32'd0);
        rst_n = 1'b1;
        mx = 0; my = 0; mmode = 0; mcnt = 0; gw = '0; gred = 1'b0;
        widx = 1'b0;
        fs_seen = 0;
        pops = 0;
        repeat (14) tick();
        chk("post_reset_mode0_pops", 32'(pops), 32'd2);
        repeat (98) tick();
        chk("post_reset_one_frame_start", 32'(fs_seen), 32'd1);
        // saturation on the continuously starved instance
        while (s_cnt !== 16'hFFFF && cyc < 90000) @(posedge clk);
        #1;
        chk("sat_reached", 32'(s_cnt), 32'hFFFF);
        repeat (300) @(posedge clk);
        #1;
        chk("sat_holds", 32'(s_cnt), 32'hFFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
